// File: rtl/jtag_bscan_tap.sv
// IEEE 1149.1 TAP controller with a parametrised boundary-scan register, IDCODE and bypass.
// Optional INTEST instruction is built in when JTAG_BSCAN_INTEST_EN is defined.
module jtag_bscan_tap #(
  parameter int unsigned NI         = 34,
  parameter int unsigned NO         = 17,
  parameter int unsigned IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic          TCK,
  input  logic          TRST,
  input  logic          TMS,
  input  logic          TDI,
  output logic          TDO,
  input  logic [NI-1:0] sys_pin_in,
  output logic [NI-1:0] module_pin_in,
  input  logic [NO-1:0] module_pin_out,
  output logic [NO-1:0] sys_pin_out
);

  localparam int unsigned BSR_W = NI + NO;
  localparam int unsigned ID_W  = 32;

  localparam logic [IR_W-1:0] OP_EXTEST = '0;
  localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(1);
  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(2);
  localparam logic [IR_W-1:0] OP_BYPASS = '1;
  localparam logic [IR_W-1:0] IR_CAPT   = IR_W'(1);
`ifdef JTAG_BSCAN_INTEST_EN
  localparam logic [IR_W-1:0] OP_INTEST = IR_W'(3);
`endif

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [2:0] {I_EXTEST, I_SAMPLE, I_IDCODE, I_INTEST, I_BYPASS} instr_e;

  tap_state_e        state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [IR_W-1:0]   ir_sh_q, ir_sh_d;
  logic [BSR_W-1:0]  bsr_sh_q, bsr_sh_d;
  logic [NO-1:0]     out_up_q, out_up_d;
  logic [ID_W-1:0]   id_sh_q, id_sh_d;
  logic              byp_q, byp_d;
  logic              tdo_q, tdo_d;
  logic              dr_tdo;
  logic              sel_bsr;
  instr_e            instr;
`ifdef JTAG_BSCAN_INTEST_EN
  logic [NI-1:0]     in_up_q, in_up_d;
`endif

  // Instruction decode: all-ones and any unassigned opcode fall through to BYPASS.
  always_comb begin
    instr = I_BYPASS;
    if (ir_q == OP_BYPASS)      instr = I_BYPASS;
    else if (ir_q == OP_EXTEST) instr = I_EXTEST;
    else if (ir_q == OP_SAMPLE) instr = I_SAMPLE;
    else if (ir_q == OP_IDCODE) instr = I_IDCODE;
`ifdef JTAG_BSCAN_INTEST_EN
    else if (ir_q == OP_INTEST) instr = I_INTEST;
`endif
  end

`ifdef JTAG_BSCAN_INTEST_EN
  assign sel_bsr = (instr == I_EXTEST) || (instr == I_SAMPLE) || (instr == I_INTEST);
`else
  assign sel_bsr = (instr == I_EXTEST) || (instr == I_SAMPLE);
`endif

  assign dr_tdo = sel_bsr ? bsr_sh_q[0] : ((instr == I_IDCODE) ? id_sh_q[0] : byp_q);

  // TAP state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = TMS ? TLR    : RTI;
      RTI:     state_d = TMS ? SEL_DR : RTI;
      SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_d = TMS ? UPD_DR : PA_DR;
      PA_DR:   state_d = TMS ? EX2_DR : PA_DR;
      EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_d = TMS ? SEL_DR : RTI;
      SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
      CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_d = TMS ? UPD_IR : PA_IR;
      PA_IR:   state_d = TMS ? EX2_IR : PA_IR;
      EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Instruction and data register datapath; pause and other states hold everything.
  always_comb begin
    ir_d     = ir_q;
    ir_sh_d  = ir_sh_q;
    bsr_sh_d = bsr_sh_q;
    out_up_d = out_up_q;
    id_sh_d  = id_sh_q;
    byp_d    = byp_q;
    tdo_d    = tdo_q;
`ifdef JTAG_BSCAN_INTEST_EN
    in_up_d  = in_up_q;
`endif
    case (state_q)
      CAP_IR: ir_sh_d = IR_CAPT;
      SH_IR: begin
        ir_sh_d = {TDI, ir_sh_q[IR_W-1:1]};
        tdo_d   = ir_sh_q[0];
      end
      UPD_IR: ir_d = ir_sh_q;
      CAP_DR: begin
        if (sel_bsr)                bsr_sh_d = {module_pin_out, sys_pin_in};
        else if (instr == I_IDCODE) id_sh_d  = IDCODE_VAL;
        else                        byp_d    = 1'b0;
      end
      SH_DR: begin
        if (sel_bsr)                bsr_sh_d = {TDI, bsr_sh_q[BSR_W-1:1]};
        else if (instr == I_IDCODE) id_sh_d  = {TDI, id_sh_q[ID_W-1:1]};
        else                        byp_d    = TDI;
        tdo_d = dr_tdo;
      end
      UPD_DR: begin
        if (sel_bsr) begin
          out_up_d = bsr_sh_q[BSR_W-1:NI];
`ifdef JTAG_BSCAN_INTEST_EN
          in_up_d  = bsr_sh_q[NI-1:0];
`endif
        end
      end
      default: ;
    endcase
    // Arriving in Test-Logic-Reset restores IDCODE (and so normal pin mode) on the same edge.
    if (state_d == TLR) ir_d = OP_IDCODE;
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q  <= TLR;
      ir_q     <= OP_IDCODE;
      ir_sh_q  <= '0;
      bsr_sh_q <= '0;
      out_up_q <= '0;
      id_sh_q  <= '0;
      byp_q    <= 1'b0;
`ifdef JTAG_BSCAN_INTEST_EN
      in_up_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ir_sh_q  <= ir_sh_d;
      bsr_sh_q <= bsr_sh_d;
      out_up_q <= out_up_d;
      id_sh_q  <= id_sh_d;
      byp_q    <= byp_d;
`ifdef JTAG_BSCAN_INTEST_EN
      in_up_q  <= in_up_d;
`endif
    end
  end

  // TDO launches on the falling edge so the next chip samples it cleanly on the rising edge.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) tdo_q <= 1'b0;
    else       tdo_q <= tdo_d;
  end

  assign TDO = tdo_q;

`ifdef JTAG_BSCAN_INTEST_EN
  assign module_pin_in = (instr == I_INTEST) ? in_up_q : sys_pin_in;
  assign sys_pin_out   = ((instr == I_EXTEST) || (instr == I_INTEST)) ? out_up_q : module_pin_out;
`else
  assign module_pin_in = sys_pin_in;
  assign sys_pin_out   = (instr == I_EXTEST) ? out_up_q : module_pin_out;
`endif

endmodule

// File: tb/tb_jtag_bscan_tap.sv
// Directed + randomized bench for jtag_bscan_tap against a stream-level JTAG reference model.
module tb_jtag_bscan_tap;
  localparam int NI = 34;
  localparam int NO = 17;
  localparam int IR_W = 4;
  localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef JTAG_BSCAN_INTEST_EN
  localparam bit INTEST_EN = 1'b1;
`else
  localparam bit INTEST_EN = 1'b0;
`endif

  logic TCK, TRST, TMS, TDI, TDO;
  logic [NI-1:0] sys_pin_in, module_pin_in;
  logic [NO-1:0] module_pin_out, sys_pin_out;

  int checks = 0;
  int errors = 0;

  // Reference model state: active opcode and the update-stage contents.
  logic [IR_W-1:0] m_ir;
  logic [NO-1:0]   m_out_up;
  logic [NI-1:0]   m_in_up;

  jtag_bscan_tap #(.NI(NI), .NO(NO), .IR_W(IR_W), .IDCODE_VAL(IDV)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .sys_pin_in(sys_pin_in), .module_pin_in(module_pin_in),
    .module_pin_out(module_pin_out), .sys_pin_out(sys_pin_out)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic bit is_bsr(input logic [IR_W-1:0] op);
    return (op == 0) || (op == 1) || (INTEST_EN && op == 3);
  endfunction

  function automatic int dr_len(input logic [IR_W-1:0] op);
    if (is_bsr(op)) return NI + NO;
    if (op == 2) return 32;
    return 1;
  endfunction

  function automatic logic [63:0] dr_capture(input logic [IR_W-1:0] op);
    logic [63:0] c;
    c = '0;
    if (is_bsr(op)) begin
      for (int i = 0; i < NI; i++) c[i] = sys_pin_in[i];
      for (int j = 0; j < NO; j++) c[NI+j] = module_pin_out[j];
    end else if (op == 2) begin
      c[31:0] = IDV;
    end
    return c;
  endfunction

  // Bit j of the serial stream seen at the DR tail: captured bits first, then TDI bits.
  function automatic logic stream_bit(input int j, input int len, input logic [63:0] cap,
                                      input logic [63:0] din);
    if (j < len) return cap[j];
    if (j - len < 64) return din[j-len];
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic pin_check(input string tag);
    bit ext, intst;
    logic [63:0] e_spo, e_mpi;
    ext   = (m_ir == 0);
    intst = INTEST_EN && (m_ir == 3);
    e_spo = (ext || intst) ? 64'(m_out_up) : 64'(module_pin_out);
    e_mpi = intst ? 64'(m_in_up) : 64'(sys_pin_in);
    check({tag, "_sys_pin_out"}, 64'(sys_pin_out), e_spo);
    check({tag, "_module_pin_in"}, 64'(module_pin_in), e_mpi);
  endtask

  // One TCK cycle: drive, sample TDO after the falling edge, then let the rising edge act.
  task automatic step(input logic tms_v, input logic tdi_v, output logic tdo_v);
    TMS = tms_v;
    TDI = tdi_v;
    @(negedge TCK);
    #1 tdo_v = TDO;
    @(posedge TCK);
    #1;
  endtask

  task automatic dr_xfer(input string tag, input int n, input logic [63:0] din,
                         output logic [63:0] dout);
    int len;
    logic [63:0] cap, exp_o;
    logic t;
    len = dr_len(m_ir);
    cap = dr_capture(m_ir);
    exp_o = '0;
    dout = '0;
    for (int i = 0; i < n; i++) exp_o[i] = stream_bit(i, len, cap, din);
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], t);
      dout[i] = t;
    end
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    if (is_bsr(m_ir)) begin
      for (int i = 0; i < NI; i++) m_in_up[i] = stream_bit(n + i, len, cap, din);
      for (int j = 0; j < NO; j++) m_out_up[j] = stream_bit(n + NI + j, len, cap, din);
    end
    check(tag, dout, exp_o);
    pin_check(tag);
  endtask

  task automatic ir_xfer(input string tag, input logic [IR_W-1:0] op);
    logic [63:0] dout;
    logic t;
    dout = '0;
    step(1'b1, 1'b0, t);
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    for (int i = 0; i < IR_W; i++) begin
      step(i == IR_W - 1, op[i], t);
      dout[i] = t;
    end
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    m_ir = op;
    check({tag, "_ir_capture"}, dout, 64'd1);
    pin_check(tag);
  endtask

  initial begin
    logic [63:0] d, o, r;
    logic t;
    TMS = 1'b1; TDI = 1'b0; TRST = 1'b1;
    r = rnd64(); sys_pin_in = r[NI-1:0];
    r = rnd64(); module_pin_out = r[NO-1:0];
    m_ir = 4'h2; m_out_up = '0; m_in_up = '0;
    #1 TRST = 1'b0;
    repeat (2) @(posedge TCK);
    #1;
    check("reset_tdo", 64'(TDO), 64'd0);
    pin_check("reset");
    TRST = 1'b1;
    step(1'b0, 1'b0, t);

    // TRST pulse in the middle of a DR shift, then read IDCODE.
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t); step(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, t);
    #2 TRST = 1'b0;
    @(negedge TCK);
    #1 check("trst_tdo", 64'(TDO), 64'd0);
    m_ir = 4'h2;
    pin_check("trst");
    @(posedge TCK);
    #1 TRST = 1'b1;
    step(1'b0, 1'b0, t);
    dr_xfer("idcode_after_trst", 32, rnd64(), o);
    check("idcode_value", o, 64'(IDV));

    // BYPASS: one-bit delay with a captured 0 in front.
    ir_xfer("bypass_f", 4'hF);
    dr_xfer("bypass_1011", 4, 64'hD, o);
    check("bypass_plan", o, 64'hA);
    dr_xfer("bypass_rand", 20, rnd64(), o);

    // SAMPLE with fixed pins, preloading output cells with 0x0F0F0.
    sys_pin_in = 34'h2_AAAA_5555;
    module_pin_out = 17'h1_2345;
    ir_xfer("sample", 4'h1);
    r = rnd64();
    d = {13'h0, 17'h0_F0F0, r[33:0]};
    dr_xfer("sample_shift", NI + NO, d, o);
    check("sample_inputs", 64'(o[33:0]), 64'h2_AAAA_5555);
    check("sample_outputs", 64'(o[50:34]), 64'h1_2345);

    // EXTEST drives the preloaded value right after UPD_IR and ignores the core.
    ir_xfer("extest", 4'h0);
    check("extest_preload", 64'(sys_pin_out), 64'h0_F0F0);
    r = rnd64(); module_pin_out = r[NO-1:0];
    r = rnd64(); sys_pin_in = r[NI-1:0];
    #1 check("extest_isolated", 64'(sys_pin_out), 64'h0_F0F0);
    pin_check("extest_pins");
    dr_xfer("extest_shift", NI + NO, rnd64(), o);

    // Five TMS=1 from Pause-IR reaches Test-Logic-Reset and restores IDCODE.
    step(1'b1, 1'b0, t); step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    m_ir = 4'h2;
    pin_check("tlr_by_tms");

    // Pause-DR holds the shift data and TDO.
    d = rnd64();
    o = '0;
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t); step(1'b0, 1'b0, t);
    for (int i = 0; i < 10; i++) begin
      step(i == 9, d[i], t);
      o[i] = t;
    end
    step(1'b0, 1'b0, t);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, t);
    check("pause_tdo_hold", 64'(t), 64'(IDV[9]));
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
    for (int i = 10; i < 32; i++) begin
      step(i == 31, d[i], t);
      o[i] = t;
    end
    step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
    check("pause_idcode", o, 64'(IDV));

    // Unknown opcode behaves as bypass.
    ir_xfer("op7", 4'h7);
    dr_xfer("op7_len1", 8, rnd64(), o);

    // Opcode 3: INTEST when built in, bypass otherwise.
    r = rnd64(); sys_pin_in = r[NI-1:0];
    ir_xfer("sample2", 4'h1);
    r = rnd64();
    d = {13'h0, r[50:34], 34'h1_0001};
    dr_xfer("preload_inputs", NI + NO, d, o);
    ir_xfer("op3", 4'h3);
`ifdef JTAG_BSCAN_INTEST_EN
    check("intest_core_in", 64'(module_pin_in), 64'h1_0001);
    r = rnd64(); sys_pin_in = r[NI-1:0];
    #1 check("intest_core_in_hold", 64'(module_pin_in), 64'h1_0001);
    dr_xfer("intest_shift", NI + NO, rnd64(), o);
`else
    dr_xfer("op3_bypass", 6, 64'h2D, o);
    check("op3_bypass_plan", o, 64'h1A);
`endif

    // Randomized instruction / data sequences.
    for (int k = 0; k < 10; k++) begin
      r = rnd64(); sys_pin_in = r[NI-1:0];
      r = rnd64(); module_pin_out = r[NO-1:0];
      ir_xfer("rand_ir", 4'($urandom_range(0, 15)));
      dr_xfer("rand_dr", $urandom_range(1, 60), rnd64(), o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
